// File: rtl/vend_pkg.sv
// Shared state encoding, coin codes and coin arithmetic for the parametrised
// vending controller and its change generator.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_1   = 2'd0;
    localparam logic [1:0] COIN_5   = 2'd1;
    localparam logic [1:0] COIN_10  = 2'd2;
    localparam logic [1:0] COIN_BAD = 2'd3;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_5:  v = 4'd5;
            COIN_10: v = 4'd10;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    // Largest coin not exceeding the remaining credit; a zero sum never reaches here.
    function automatic logic [1:0] best_coin(input logic [15:0] sum);
        logic [1:0] c;
        if (sum >= 16'd10) begin
            c = COIN_10;
        end else if (sum >= 16'd5) begin
            c = COIN_5;
        end else begin
            c = COIN_1;
        end
        return c;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Combinational change picker: largest coin fitting the current credit and the
// amount to subtract when it is paid out.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int SUM_W = 6
) (
    input  logic [SUM_W-1:0] i_sum,
    output logic [1:0]       o_coin,
    output logic [SUM_W-1:0] o_dec
);

    assign o_coin = best_coin(16'(i_sum));
    assign o_dec  = SUM_W'(coin_value(o_coin));

endmodule

// File: rtl/vend_fsm_n.sv
// Parametrised vending-machine controller: credit accumulation, drink release,
// inactivity refund and coin-by-coin change payout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no credit, waiting for the first valid coin
// S_HOLD   | credit held, accepting coins / purchase / cancel, timer runs
// S_VEND   | one-cycle drink release, price already deducted
// S_CHANGE | paying remaining credit back one coin per cycle
module vend_fsm_n
    import vend_pkg::*;
#(
    parameter int                      NUM_DRINKS  = 4,
    parameter int                      SUM_W       = 6,
    parameter int                      MAX_SUM     = 50,
    parameter logic [8*NUM_DRINKS-1:0] PRICES      = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                      TIMEOUT_CYC = 30,
    parameter int                      SEL_W       = $clog2(NUM_DRINKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  insert,
    input  logic [1:0]            coin_val,
    input  logic                  drink_req,
    input  logic [SEL_W-1:0]      drink_sel,
    input  logic                  cancel_flag,
    output logic                  hold_ind,
    output logic [NUM_DRINKS-1:0] drink_ind,
    output logic                  vend_valid,
    output logic [SEL_W-1:0]      vend_id,
    output logic                  chg_valid,
    output logic [1:0]            chg_coin,
    output logic                  reject,
    output logic [SUM_W-1:0]      coin_sum
);

    localparam int               TMR_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(TIMEOUT_CYC);
    localparam logic [SUM_W:0]   MAX_SUM_W = (SUM_W + 1)'(MAX_SUM);

    vend_state_t      r_state, w_state_nxt;
    logic [SUM_W-1:0] r_sum, w_sum_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic             r_vend_valid, w_vend_valid_nxt;
    logic [SEL_W-1:0] r_vend_id, w_vend_id_nxt;
    logic             r_chg_valid, w_chg_valid_nxt;
    logic [1:0]       r_chg_coin, w_chg_coin_nxt;
    logic             r_reject, w_reject_nxt;

    logic [7:0]       w_price;
    logic             w_sel_ok;
    logic             w_afford;
    logic [SUM_W:0]   w_add;
    logic             w_coin_ok;
    logic [1:0]       w_chg_code;
    logic [SUM_W-1:0] w_chg_dec;

    vend_change_gen #(
        .SUM_W (SUM_W)
    ) u_chg (
        .i_sum  (r_sum),
        .o_coin (w_chg_code),
        .o_dec  (w_chg_dec)
    );

    // Select decode also covers non-power-of-two drink counts.
    always_comb begin
        w_price  = '0;
        w_sel_ok = 1'b0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (drink_sel == SEL_W'(i)) begin
                w_price  = PRICES[8*i +: 8];
                w_sel_ok = 1'b1;
            end
        end
    end

    assign w_afford  = (32'(r_sum) >= 32'(w_price));
    assign w_add     = {1'b0, r_sum} + (SUM_W + 1)'(coin_value(coin_val));
    assign w_coin_ok = (coin_val != COIN_BAD) && (w_add <= MAX_SUM_W);

    always_comb begin
        w_state_nxt      = r_state;
        w_sum_nxt        = r_sum;
        w_tmr_nxt        = '0;
        w_vend_valid_nxt = 1'b0;
        w_vend_id_nxt    = '0;
        w_chg_valid_nxt  = 1'b0;
        w_chg_coin_nxt   = COIN_1;
        w_reject_nxt     = 1'b0;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (r_state == S_HOLD) begin
                    w_tmr_nxt = (r_tmr == TMR_SAT) ? r_tmr : r_tmr + TMR_W'(1);
                end
                if (cancel_flag) begin
                    w_reject_nxt = insert;
                    if (r_state == S_HOLD) begin
                        w_state_nxt = S_CHANGE;
                    end
                end else if (drink_req) begin
                    w_reject_nxt = insert;
                    if ((r_state == S_HOLD) && w_sel_ok && w_afford) begin
                        w_state_nxt      = S_VEND;
                        w_vend_valid_nxt = 1'b1;
                        w_vend_id_nxt    = drink_sel;
                        w_sum_nxt        = r_sum - SUM_W'(w_price);
                    end
                end else if (insert) begin
                    if (w_coin_ok) begin
                        w_sum_nxt   = w_add[SUM_W-1:0];
                        w_state_nxt = S_HOLD;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end else if ((r_state == S_HOLD) && (r_tmr >= TMR_LAST)) begin
                    w_state_nxt = S_CHANGE;
                end
            end
            S_VEND: begin
                w_reject_nxt = insert;
                w_state_nxt  = (r_sum != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                w_reject_nxt = insert;
                if (r_sum == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_chg_valid_nxt = 1'b1;
                    w_chg_coin_nxt  = w_chg_code;
                    w_sum_nxt       = r_sum - w_chg_dec;
                    if (r_sum == w_chg_dec) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sum        <= '0;
            r_tmr        <= '0;
            r_vend_valid <= 1'b0;
            r_vend_id    <= '0;
            r_chg_valid  <= 1'b0;
            r_chg_coin   <= COIN_1;
            r_reject     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sum        <= w_sum_nxt;
            r_tmr        <= w_tmr_nxt;
            r_vend_valid <= w_vend_valid_nxt;
            r_vend_id    <= w_vend_id_nxt;
            r_chg_valid  <= w_chg_valid_nxt;
            r_chg_coin   <= w_chg_coin_nxt;
            r_reject     <= w_reject_nxt;
        end
    end

    always_comb begin
        drink_ind = '0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            drink_ind[i] = (r_state == S_HOLD) && (32'(r_sum) >= 32'(PRICES[8*i +: 8]));
        end
    end

    assign hold_ind   = (r_state == S_HOLD);
    assign vend_valid = r_vend_valid;
    assign vend_id    = r_vend_id;
    assign chg_valid  = r_chg_valid;
    assign chg_coin   = r_chg_coin;
    assign reject     = r_reject;
    assign coin_sum   = r_sum;

endmodule

// File: doc/vend_fsm_n.md
Name: vend_fsm_n

Overview:
Parametrised vending-machine controller, the successor to the fixed two-drink FSM.
- Supports NUM_DRINKS products with a per-product price table and a parametrised credit width.
- Rejects invalid or overflowing coins; auto-refunds on inactivity timeout.
- Dispenses change coin by coin, largest first.
- Sits between the 1 Hz clock divider and the digit decoder; coin_sum feeds the display path unchanged.

Parameters:
- NUM_DRINKS, 4, number of selectable products (2..8).
- SUM_W, 6, credit register width in units.
- MAX_SUM, 50, largest credit accepted; must be < 2**SUM_W.
- PRICES, {8'd25,8'd20,8'd15,8'd10}, packed 8-bit prices; entry i is the price of drink i (LSB slice = drink 0). Every price must be ≤ MAX_SUM and ≥ 1.
- TIMEOUT_CYC, 30, idle cycles in HOLD before auto-refund (30 s at 1 Hz).
- SEL_W, $clog2(NUM_DRINKS), drink select width (derived).

Ports:
- clk, in, 1, rising-edge system clock.
- rst_n, in, 1, asynchronous active-low reset.
- insert, in, 1, single-cycle coin strobe.
- coin_val, in, 2, coin code: 0=1 unit, 1=5, 2=10, 3=invalid.
- drink_req, in, 1, single-cycle purchase strobe.
- drink_sel, in, SEL_W, product index sampled with drink_req.
- cancel_flag, in, 1, refund request (level, acted on when sampled high).
- hold_ind, out, 1, high in HOLD.
- drink_ind, out, NUM_DRINKS, bit i high when in HOLD and coin_sum ≥ PRICES[i].
- vend_valid, out, 1, one-cycle pulse when a drink is released.
- vend_id, out, SEL_W, index of the released drink, valid with vend_valid, else 0.
- chg_valid, out, 1, high for each cycle a change coin is emitted.
- chg_coin, out, 2, coin code of the emitted coin, valid with chg_valid.
- reject, out, 1, one-cycle pulse when a coin is refused.
- coin_sum, out, SUM_W, current credit (registered).

Behaviour:
- Reset (async, rst_n=0): state IDLE, coin_sum=0, all outputs 0, timer=0. Deassertion is synchronised externally; first active edge after release samples inputs normally.
- States: IDLE, HOLD, VEND, CHANGE.
- Input priority in IDLE/HOLD: cancel_flag > drink_req > insert.
  - A lower-priority event in the same cycle is dropped.
  - A dropped insert pulses reject.
- Insert, IDLE/HOLD:
  - Code 3, or coin_sum + value > MAX_SUM: reject=1 next cycle, coin_sum unchanged, state unchanged.
  - Otherwise: coin_sum += value next cycle, state→HOLD, timer cleared.
  - Insert in VEND/CHANGE: reject pulse, credit unchanged.
- drink_req in HOLD:
  - drink_sel < NUM_DRINKS and coin_sum ≥ PRICES[drink_sel]: next cycle state=VEND, vend_valid=1, vend_id=drink_sel, coin_sum -= price.
  - Otherwise: request ignored, no output change.
  - drink_req in IDLE is ignored.
- VEND lasts exactly one cycle. Next state is CHANGE if coin_sum > 0, else IDLE.
- cancel_flag in HOLD → CHANGE next cycle. cancel_flag in IDLE has no effect.
- Timeout:
  - In HOLD, the timer counts cycles without an accepted insert.
  - When the timer reaches TIMEOUT_CYC-1 and no event is present, the next state is CHANGE.
  - Timer width is $clog2(TIMEOUT_CYC+1).
- CHANGE, one coin per cycle:
  - Emitted coin is the largest value ≤ coin_sum (10, else 5, else 1).
  - chg_valid=1, chg_coin=code, coin_sum -= value (same registered update).
  - When coin_sum reaches 0 after the update, next state is IDLE and chg_valid drops.
  - cancel_flag and drink_req are ignored in CHANGE.
- Output timing:
  - vend_valid, vend_id, chg_valid, chg_coin and reject are registered.
  - drink_ind and hold_ind are decoded from registered state and coin_sum; no combinational input-to-output path.
- Width rule: all additions are done at SUM_W+1 bits before the MAX_SUM compare, so the sum never wraps.
- Reset mid-CHANGE or mid-VEND: credit is lost and state→IDLE. This is accepted behaviour.

Decomposition:
- Package vend_pkg:
  - State enum.
  - Coin code constants COIN_1, COIN_5, COIN_10, COIN_BAD.
  - Function coin_value(code) returning units.
  - Function best_coin(sum) returning a code.
- Sub-module vend_change_gen: given coin_sum, produces chg_coin code and decrement value combinationally. Instantiated once.

Test Plan:
- Reset mid-HOLD with coin_sum=15 → all outputs 0, coin_sum=0 while rst_n=0, state IDLE.
- Insert codes 2,2,1 (25), drink_req sel=0 (price 10) → vend_valid, vend_id=0, coin_sum=15; then chg_coin 10 then 5 on consecutive cycles; then IDLE with coin_sum=0.
- Insert code 3 → reject pulse, coin_sum unchanged. Credit 45 + code 2 → reject, sum stays 45. Credit 45 + code 1 → sum 50.
- Credit 10, drink_req sel=3 (price 25) → ignored, drink_ind=4'b0001, no vend_valid.
- Same cycle cancel_flag + drink_req + insert with credit 20 → CHANGE, reject pulse, change 10,10.
- Insert 7 (codes 1,0,0), then no activity for TIMEOUT_CYC cycles → change 5,1,1, then IDLE.
